// File: rtl/sharpness_ctrl_pkg.sv
// Shared types and constants for the sharpness preprocess sequencer.
// Frame statistics are enabled by defining SHARPNESS_STAT_EN.
package sharpness_ctrl_pkg;

   localparam int THR_W = 13;

   typedef enum logic [1:0] {
      V_BLANK = 2'd0,
      H_BLANK = 2'd1,
      ACTIVE  = 2'd2,
      OVERRUN = 2'd3
   } shp_state_e;

   localparam int STAT_CFG_ERR    = 0;
   localparam int STAT_LINE_OVF   = 1;
   localparam int STAT_LINE_SHORT = 2;

   function automatic logic [2:0] popcount4(input logic [3:0] v);
      return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
   endfunction

endpackage

// File: rtl/shp_frame_stat.sv
// Per-frame count of sharpened subpixels: popcount, saturating accumulator, output latch.
// Present only when SHARPNESS_STAT_EN is defined.
`ifdef SHARPNESS_STAT_EN
module shp_frame_stat
   import sharpness_ctrl_pkg::*;
#(
   parameter int STAT_W = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              acc_en,
   input  logic [3:0]        sel,
   input  logic              xfer,
   input  logic              clr,
   output logic [STAT_W-1:0] stat_count
);

   logic [STAT_W-1:0] acc_q, acc_d;
   logic [STAT_W-1:0] stat_q, stat_d;
   logic [STAT_W-1:0] sum;

   function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                 input logic [2:0] b);
      logic [STAT_W:0] s;
      s = {1'b0, a} + {{(STAT_W-2){1'b0}}, b};
      return s[STAT_W] ? {STAT_W{1'b1}} : s[STAT_W-1:0];
   endfunction

   always_comb begin
      sum    = acc_en ? sat_add(acc_q, popcount4(sel)) : acc_q;
      acc_d  = clr ? '0 : sum;
      stat_d = xfer ? sum : stat_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q  <= '0;
         stat_q <= '0;
      end else begin
         acc_q  <= acc_d;
         stat_q <= stat_d;
      end
   end

   assign stat_count = stat_q;

endmodule
`endif

// File: rtl/sharpness_ctrl.sv
// Line/frame sequencer for the sharpness preprocess stage: load enable, border marks,
// frame-synchronous config shadowing and status. Optional statistics: SHARPNESS_STAT_EN.
module sharpness_ctrl
   import sharpness_ctrl_pkg::*;
#(
   parameter int BEAT_W = 11,
   parameter int LINE_W = 11,
   parameter int STAT_W = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_hs,
   input  logic              i_vs,
   input  logic              cfg_sharp_en,
   input  logic [THR_W-1:0]  cfg_thr_hi,
   input  logic [THR_W-1:0]  cfg_thr_lo,
   input  logic [BEAT_W-1:0] cfg_line_beats,
   input  logic [3:0]        shp_sel_in,
   output logic              spr_sharp_en,
   output logic [THR_W-1:0]  spr_thr_hi,
   output logic [THR_W-1:0]  spr_thr_lo,
   output logic              shp_pre_en,
   output logic              o_border,
   output logic [LINE_W-1:0] line_cnt,
   output logic              frame_done,
   output logic [STAT_W-1:0] stat_count,
   output logic [2:0]        o_status
);

   logic hs_q, vs_q;
   logic hs_rise, hs_fall, vs_rise, vs_fall;

   shp_state_e        state_q, state_d, beat_state;
   logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d, beat_eff;
   logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
   logic              pre_en_q, pre_en_d;
   logic              border_q, border_d;
   logic              frame_done_q, frame_done_d;
   logic              sharp_en_q, sharp_en_d;
   logic [THR_W-1:0]  thr_hi_q, thr_hi_d;
   logic [THR_W-1:0]  thr_lo_q, thr_lo_d;
   logic [2:0]        status_q, status_d;
   logic              line_end;

   // Edge-detect flops are left out of reset so a frame in flight during rst
   // does not look like a fresh i_vs rise afterwards.
   always_ff @(posedge clk) begin
      hs_q <= i_hs;
      vs_q <= i_vs;
   end

   assign hs_rise = i_hs & ~hs_q;
   assign hs_fall = ~i_hs & hs_q;
   assign vs_rise = i_vs & ~vs_q;
   assign vs_fall = ~i_vs & vs_q;

   // state_d is the classification of the current input cycle; V_BLANK is left
   // only on an i_vs rise, and a line starts only on an i_hs rise.
   always_comb begin
      beat_eff   = hs_rise ? '0 : beat_cnt_q;
      beat_state = (beat_eff < cfg_line_beats) ? ACTIVE : OVERRUN;
      state_d    = state_q;
      if (!i_vs) begin
         state_d = V_BLANK;
      end else begin
         unique case (state_q)
            V_BLANK: if (vs_rise) state_d = hs_rise ? beat_state : H_BLANK;
            H_BLANK: state_d = hs_rise ? beat_state : H_BLANK;
            default: state_d = i_hs ? beat_state : H_BLANK;
         endcase
      end
   end

   always_comb begin
      line_end     = hs_fall && (state_q == ACTIVE || state_q == OVERRUN);
      beat_cnt_d   = beat_cnt_q;
      line_cnt_d   = line_cnt_q;
      sharp_en_d   = sharp_en_q;
      thr_hi_d     = thr_hi_q;
      thr_lo_d     = thr_lo_q;
      status_d     = status_q;
      pre_en_d     = (state_d == ACTIVE);
      border_d     = pre_en_d &&
                     (beat_eff == '0 || beat_eff == (cfg_line_beats - BEAT_W'(1)));
      frame_done_d = vs_fall && (state_q != V_BLANK);

      if (state_d == ACTIVE) beat_cnt_d = beat_eff + BEAT_W'(1);
      else if (hs_rise)      beat_cnt_d = '0;

      if (vs_rise)       line_cnt_d = '0;
      else if (line_end) line_cnt_d = line_cnt_q + LINE_W'(1);

      if (vs_rise) begin
         sharp_en_d = cfg_sharp_en;
         if (cfg_thr_lo <= cfg_thr_hi) begin
            thr_hi_d = cfg_thr_hi;
            thr_lo_d = cfg_thr_lo;
         end else begin
            status_d[STAT_CFG_ERR] = 1'b1;
         end
      end
      if (state_d == OVERRUN)
         status_d[STAT_LINE_OVF] = 1'b1;
      if (line_end && (beat_cnt_q < cfg_line_beats))
         status_d[STAT_LINE_SHORT] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= V_BLANK;
         beat_cnt_q   <= '0;
         line_cnt_q   <= '0;
         pre_en_q     <= 1'b0;
         border_q     <= 1'b0;
         frame_done_q <= 1'b0;
         sharp_en_q   <= 1'b0;
         thr_hi_q     <= '0;
         thr_lo_q     <= '0;
         status_q     <= '0;
      end else begin
         state_q      <= state_d;
         beat_cnt_q   <= beat_cnt_d;
         line_cnt_q   <= line_cnt_d;
         pre_en_q     <= pre_en_d;
         border_q     <= border_d;
         frame_done_q <= frame_done_d;
         sharp_en_q   <= sharp_en_d;
         thr_hi_q     <= thr_hi_d;
         thr_lo_q     <= thr_lo_d;
         status_q     <= status_d;
      end
   end

   assign spr_sharp_en = sharp_en_q;
   assign spr_thr_hi   = thr_hi_q;
   assign spr_thr_lo   = thr_lo_q;
   assign shp_pre_en   = pre_en_q;
   assign o_border     = border_q;
   assign line_cnt     = line_cnt_q;
   assign frame_done   = frame_done_q;
   assign o_status     = status_q;

`ifdef SHARPNESS_STAT_EN
   shp_frame_stat #(.STAT_W(STAT_W)) u_frame_stat (
      .clk        (clk),
      .rst        (rst),
      .acc_en     (pre_en_q & ~border_q),
      .sel        (shp_sel_in),
      .xfer       (frame_done_d),
      .clr        (frame_done_q),
      .stat_count (stat_count)
   );
`else
   logic unused_sel;
   assign unused_sel = ^shp_sel_in;
   assign stat_count = '0;
`endif

endmodule
